unidad_control_multiciclo: RTL



---
 rtl/unidad_control_multiciclo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/unidad_control_multiciclo.sv
// Multicycle control unit: sequences fetch, decode, execute, memory and
// write-back, and drives every datapath select/enable from the current state.
module unidad_control_multiciclo (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic [1:0] MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PC_En,
    output logic       Instr_Done,
    output logic       Error,
    output logic [3:0] Estado
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        INIT      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL       = 4'd13,
        ERROR     = 4'd14
    } state_t;

    state_t state;
    state_t next_state;

    assign Estado = state;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and state-decoded datapath controls.
    always_comb begin
        next_state = INIT;
        RegDst     = 2'd0;
        RegWrite   = 1'b0;
        MemtoReg   = 2'd0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ALUOp      = 2'd0;
        PCSource   = 2'd0;
        PC_En      = 1'b0;
        Instr_Done = 1'b0;
        Error      = 1'b0;

        case (state)
            INIT: begin
                next_state = FETCH;
            end
            FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'd1;
                IRWrite    = Mem_Ready;
                PC_En      = Mem_Ready;
                next_state = Mem_Ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'd3;
                case (Opcode)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_R:         next_state = R_EXEC;
                    OP_ADDI:      next_state = I_EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = ERROR;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                // Opcode is held by the IR, so it still tells lw from sw here.
                if (Opcode == OP_LW) begin
                    next_state = MEM_READ;
                end else if (Opcode == OP_SW) begin
                    next_state = MEM_WRITE;
                end else begin
                    next_state = INIT;
                end
            end
            MEM_READ: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = Mem_Ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'd1;
                Instr_Done = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                Instr_Done = Mem_Ready;
                next_state = Mem_Ready ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'd2;
                next_state = R_WB;
            end
            R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'd1;
                Instr_Done = 1'b1;
                next_state = FETCH;
            end
            I_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                next_state = I_WB;
            end
            I_WB: begin
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'd1;
                PCSource   = 2'd1;
                PC_En      = Zero;
                Instr_Done = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                PCSource   = 2'd2;
                PC_En      = 1'b1;
                Instr_Done = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH; it is written to r31 while
                // the jump target is loaded in the same cycle.
                RegWrite   = 1'b1;
                RegDst     = 2'd2;
                MemtoReg   = 2'd2;
                PCSource   = 2'd2;
                PC_En      = 1'b1;
                Instr_Done = 1'b1;
                next_state = FETCH;
            end
            ERROR: begin
                Error      = 1'b1;
                next_state = ERROR;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

endmodule
